mcu_nbit_core: RTL and testbench

MCU_NBIT_CORE -- requirements
Module: mcu_nbit_core

---
 rtl/mcu_nbit_core.sv | 208 ++++++++++++++++++++
 tb/tb_mcu_nbit_core.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_nbit_core.sv
// Accumulator MCU core: two-cycle FETCH/EXEC instruction sequencer with a
// loadable instruction memory, a register file and a small ALU.
module mcu_nbit_core #(
  parameter int DATA_W = 8,
  parameter int OPND_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              ImemWe,
  input  logic [OPND_W-1:0] ImemAddr,
  input  logic [OPND_W+3:0] ImemData,
  output logic [OPND_W-1:0] CurrentPC,
  output logic [DATA_W-1:0] AccOut,
  output logic              FlagZ,
  output logic              FlagC,
  output logic              Busy,
  output logic              Halted
);

  localparam int DEPTH = 2 ** OPND_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_JR  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [1:0]        r_state;
  logic [OPND_W-1:0] r_pc;
  logic [OPND_W+3:0] r_ir;
  logic [DATA_W-1:0] r_acc;
  logic              r_z;
  logic              r_c;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [OPND_W+3:0] r_imem [DEPTH];

  logic [3:0]        w_op;
  logic [OPND_W-1:0] w_opnd;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_regVal;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_nextAcc;
  logic              w_nextC;
  logic              w_nextZ;
  logic              w_updFlags;
  logic              w_jumpTaken;
  logic [OPND_W-1:0] w_jumpTarget;
  logic              w_imemWrEn;

  assign w_op     = r_ir[OPND_W+3:OPND_W];
  assign w_opnd   = r_ir[OPND_W-1:0];
  assign w_imm    = DATA_W'(w_opnd);
  assign w_regVal = r_regs[w_opnd];

  // The extra top bit of the difference is the borrow out of the subtraction.
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_regVal};
  assign w_diff = {1'b0, r_acc} - {1'b0, w_regVal};

  always_comb begin
    w_nextAcc    = r_acc;
    w_nextC      = r_c;
    w_updFlags   = 1'b0;
    w_jumpTaken  = 1'b0;
    w_jumpTarget = w_opnd;
    case (w_op)
      OP_LDI: begin
        w_nextAcc  = w_imm;
        w_updFlags = 1'b1;
      end
      OP_LDR: begin
        w_nextAcc  = w_regVal;
        w_updFlags = 1'b1;
      end
      OP_ADD: begin
        {w_nextC, w_nextAcc} = w_sum;
        w_updFlags           = 1'b1;
      end
      OP_SUB: begin
        w_nextAcc  = w_diff[DATA_W-1:0];
        w_nextC    = w_diff[DATA_W];
        w_updFlags = 1'b1;
      end
      OP_AND: begin
        w_nextAcc  = r_acc & w_regVal;
        w_nextC    = 1'b0;
        w_updFlags = 1'b1;
      end
      OP_OR: begin
        w_nextAcc  = r_acc | w_regVal;
        w_nextC    = 1'b0;
        w_updFlags = 1'b1;
      end
      OP_XOR: begin
        w_nextAcc  = r_acc ^ w_regVal;
        w_nextC    = 1'b0;
        w_updFlags = 1'b1;
      end
      OP_SHL: begin
        w_nextAcc  = r_acc << 1;
        w_nextC    = r_acc[DATA_W-1];
        w_updFlags = 1'b1;
      end
      OP_SHR: begin
        w_nextAcc  = r_acc >> 1;
        w_nextC    = r_acc[0];
        w_updFlags = 1'b1;
      end
      OP_JMP: w_jumpTaken = 1'b1;
      OP_JZ:  w_jumpTaken = r_z;
      OP_JC:  w_jumpTaken = r_c;
      OP_JR: begin
        w_jumpTaken  = 1'b1;
        w_jumpTarget = w_regVal[OPND_W-1:0];
      end
      default: begin
        w_nextAcc = r_acc;
      end
    endcase
  end

  assign w_nextZ = w_updFlags ? (w_nextAcc == '0) : r_z;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_acc   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Run) begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_ir    <= r_imem[r_pc];
          r_pc    <= r_pc + 1'b1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_acc <= w_nextAcc;
          r_c   <= w_updFlags ? w_nextC : r_c;
          r_z   <= w_nextZ;
          if (w_op == OP_STR) begin
            r_regs[w_opnd] <= r_acc;
          end
          if (w_jumpTaken) begin
            r_pc <= w_jumpTarget;
          end
          // A Run drop only takes effect once the current instruction retires.
          if (w_op == OP_HLT) begin
            r_state <= S_HALT;
          end else if (Run) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          if (!Run) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Program memory survives reset so a loaded program can be rerun.
  assign w_imemWrEn = ImemWe && ((r_state == S_IDLE) || (r_state == S_HALT));

  always_ff @(posedge Clk) begin
    if (w_imemWrEn) begin
      r_imem[ImemAddr] <= ImemData;
    end
  end

  assign CurrentPC = r_pc;
  assign AccOut    = r_acc;
  assign FlagZ     = r_z;
  assign FlagC     = r_c;
  assign Busy      = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign Halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_mcu_nbit_core.sv
// Self-checking bench for mcu_nbit_core: directed programs plus random programs
// compared instruction-by-instruction against an instruction-level model.
module tb_mcu_nbit_core;

  localparam int DW    = 8;
  localparam int OW    = 4;
  localparam int DEPTH = 16;
  localparam int MASK  = 255;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Run;
  logic          ImemWe;
  logic [OW-1:0] ImemAddr;
  logic [OW+3:0] ImemData;
  logic [OW-1:0] CurrentPC;
  logic [DW-1:0] AccOut;
  logic          FlagZ;
  logic          FlagC;
  logic          Busy;
  logic          Halted;

  int checks = 0;
  int errors = 0;

  int mPc, mAcc, mZ, mC, mHalt;
  int mReg  [DEPTH];
  int mImem [DEPTH];

  mcu_nbit_core #(.DATA_W(DW), .OPND_W(OW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ImemWe(ImemWe), .ImemAddr(ImemAddr),
    .ImemData(ImemData), .CurrentPC(CurrentPC), .AccOut(AccOut), .FlagZ(FlagZ),
    .FlagC(FlagC), .Busy(Busy), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // Hard stop in case the sequencing ever wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic modelReset();
    mPc = 0; mAcc = 0; mZ = 0; mC = 0; mHalt = 0;
    for (int i = 0; i < DEPTH; i++) mReg[i] = 0;
  endtask

  // One whole instruction at the architectural level.
  task automatic modelStep();
    int w, op, opnd, r;
    w    = mImem[mPc];
    op   = (w >> OW) & 15;
    opnd = w & (DEPTH - 1);
    r    = mReg[opnd];
    mPc  = (mPc + 1) % DEPTH;
    case (op)
      1:  mAcc = opnd;
      2:  mAcc = r;
      3:  mReg[opnd] = mAcc;
      4:  begin mC = ((mAcc + r) > MASK) ? 1 : 0; mAcc = (mAcc + r) & MASK; end
      5:  begin mC = (mAcc < r) ? 1 : 0; mAcc = (mAcc - r) & MASK; end
      6:  begin mAcc = mAcc & r; mC = 0; end
      7:  begin mAcc = mAcc | r; mC = 0; end
      8:  begin mAcc = mAcc ^ r; mC = 0; end
      9:  begin mC = (mAcc >> (DW - 1)) & 1; mAcc = (mAcc * 2) & MASK; end
      10: begin mC = mAcc & 1; mAcc = mAcc / 2; end
      11: mPc = opnd;
      12: if (mZ == 1) mPc = opnd;
      13: if (mC == 1) mPc = opnd;
      14: mPc = r % DEPTH;
      15: mHalt = 1;
      default: ;
    endcase
    if ((op == 1) || (op == 2) || ((op >= 4) && (op <= 10))) mZ = (mAcc == 0) ? 1 : 0;
  endtask

  task automatic checkArch(input string tag);
    checkOutput({tag, ".pc"}, 32'(CurrentPC), mPc);
    checkOutput({tag, ".acc"}, 32'(AccOut), mAcc);
    checkOutput({tag, ".z"}, 32'(FlagZ), mZ);
    checkOutput({tag, ".c"}, 32'(FlagC), mC);
    checkOutput({tag, ".halted"}, 32'(Halted), mHalt);
  endtask

  task automatic loadWord(input int addr, input int data);
    ImemWe   = 1'b1;
    ImemAddr = OW'(addr);
    ImemData = (OW + 4)'(data);
    tick();
    ImemWe   = 1'b0;
    mImem[addr] = data;
  endtask

  task automatic doReset(input string tag);
    Reset = 1'b0;
    #1;
    modelReset();
    checkArch(tag);
    checkOutput({tag, ".busy"}, 32'(Busy), 0);
    Reset = 1'b1;
    Run   = 1'b0;
    #1;
  endtask

  task automatic startRun();
    Run = 1'b1;
    tick();
    checkOutput("start.busy", 32'(Busy), 1);
  endtask

  // Runs one instruction from FETCH, optionally dropping Run mid-instruction
  // and hammering ImemWe (which must be ignored while busy).
  task automatic applyStimulus(input bit dropRun, input bit noise);
    if (noise) begin
      ImemWe   = 1'b1;
      ImemAddr = OW'($urandom_range(DEPTH - 1, 0));
      ImemData = (OW + 4)'($urandom_range(255, 0));
    end
    tick();
    checkOutput("exec.busy", 32'(Busy), 1);
    if (dropRun) Run = 1'b0;
    if (noise) begin
      ImemAddr = OW'($urandom_range(DEPTH - 1, 0));
      ImemData = (OW + 4)'($urandom_range(255, 0));
    end
    tick();
    ImemWe = 1'b0;
    modelStep();
    checkArch("instr");
    if (mHalt == 1) begin
      checkOutput("halt.busy", 32'(Busy), 0);
      Run = 1'b1;
      tick();
      checkOutput("haltHold.halted", 32'(Halted), 1);
      checkOutput("haltHold.pc", 32'(CurrentPC), mPc);
      Run = 1'b0;
      tick();
      checkOutput("haltExit.halted", 32'(Halted), 0);
      checkOutput("haltExit.busy", 32'(Busy), 0);
      mHalt = 0;
      startRun();
    end else if (dropRun) begin
      checkOutput("drop.busy", 32'(Busy), 0);
      startRun();
    end
  endtask

  initial begin
    Reset = 1'b0; Run = 1'b0; ImemWe = 1'b0; ImemAddr = '0; ImemData = '0;
    for (int i = 0; i < DEPTH; i++) mImem[i] = 0;
    modelReset();
    #12;
    checkArch("por");
    checkOutput("por.busy", 32'(Busy), 0);
    Reset = 1'b1;
    #1;

    $display("[TB] basic LDI/ADD/STR/HLT program");
    loadWord(0, 8'h15); loadWord(1, 8'h40); loadWord(2, 8'h31); loadWord(3, 8'hF0);
    startRun();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("basic.acc", 32'(AccOut), 5);
    checkOutput("basic.pc", 32'(CurrentPC), 4);
    checkOutput("basic.z", 32'(FlagZ), 0);
    doReset("rst1");

    $display("[TB] ADD carry chain");
    loadWord(0, 8'h1F); loadWord(1, 8'h32); loadWord(2, 8'h1F);
    for (int i = 3; i < 7; i++) loadWord(i, 8'h90);
    loadWord(7, 8'h42); loadWord(8, 8'h42); loadWord(9, 8'hF0);
    startRun();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("add1.acc", 32'(AccOut), 8'hFF);
    checkOutput("add1.c", 32'(FlagC), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("add2.acc", 32'(AccOut), 8'h0E);
    checkOutput("add2.c", 32'(FlagC), 1);
    checkOutput("add2.z", 32'(FlagZ), 0);
    doReset("rst2");

    $display("[TB] SUB borrow and JZ");
    loadWord(0, 8'h13); loadWord(1, 8'h33); loadWord(2, 8'h13); loadWord(3, 8'h53);
    loadWord(4, 8'hC9); loadWord(9, 8'h12); loadWord(10, 8'h53); loadWord(11, 8'hC0);
    loadWord(12, 8'hF0);
    startRun();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("jz.pc", 32'(CurrentPC), 9);
    checkOutput("jz.z", 32'(FlagZ), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("borrow.acc", 32'(AccOut), 8'hFF);
    checkOutput("borrow.c", 32'(FlagC), 1);
    checkOutput("nojump.pc", 32'(CurrentPC), 12);
    doReset("rst3");

    $display("[TB] PC wrap with busy-time write attempts");
    loadWord(0, 8'hBE); loadWord(14, 8'hBF); loadWord(15, 8'h00);
    startRun();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("wrap.pc", 32'(CurrentPC), 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1);
    doReset("rst4");

    $display("[TB] reset during STR");
    loadWord(0, 8'h1A);
    for (int i = 1; i < 5; i++) loadWord(i, 8'h90);
    loadWord(5, 8'h32); loadWord(6, 8'h1A); loadWord(7, 8'h72); loadWord(8, 8'h31);
    loadWord(9, 8'hF0);
    startRun();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("preStr.acc", 32'(AccOut), 8'hAA);
    tick();
    checkOutput("strExec.busy", 32'(Busy), 1);
    doReset("strAbort");
    loadWord(0, 8'h21); loadWord(1, 8'hF0);
    startRun();
    applyStimulus(1'b0, 1'b0);
    checkOutput("reg1Cleared.acc", 32'(AccOut), 0);
    checkOutput("reg1Cleared.z", 32'(FlagZ), 1);
    doReset("rst5");

    $display("[TB] random programs");
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < DEPTH; a++) loadWord(a, $urandom_range(255, 0));
      startRun();
      for (int k = 0; k < 40; k++) applyStimulus(($urandom_range(4, 0) == 0), ($urandom_range(2, 0) == 0));
      doReset("rndRst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
